fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage controller for the five-stage RV64 pipeline. Owns the architectural PC register and sequences instruction-bus requests, with a one-entry skid buffer. It resolves redirects that arrive while a fetch is in flight by draining and discarding the stale response. It also produces the per-stage stall/flush controls, using a fixed priority: memory stall > execute stall > branch redirect > load-use > normal fetch.

## Interface
- RESET_PC, 64'h8000_0000, PC after reset.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  64  request address.
- iresp_data_ok  in  1  one-cycle pulse: response for the outstanding request.
- iresp_data  in  32  instruction word, valid with iresp_data_ok.
- redirect  in  1  taken branch/jump resolved in execute.
- redirect_pc  in  64  redirect target.
- stall_mem  in  1  memory stage busy.
- stall_exe  in  1  multicycle execute busy.
- stall_loaduse  in  1  decode load-use hazard.
- f_valid  out  1  F/D latch holds a valid instruction.
- f_pc  out  64  PC of the F/D instruction.
- f_instr  out  32  F/D instruction word.
- stall_d, stall_e, stall_m  out  1 each  hold the D, E or M pipeline register.
- flush_d, flush_e  out  1 each  invalidate the D or E pipeline register.

## Operation
- Qualified redirect is `redirect & !stall_mem & !stall_exe`. An unqualified redirect is ignored; execute holds it.
- Combinational controls, highest priority first:
  - stall_mem: stall_d/e/m=1.
  - stall_exe: stall_d/e=1, stall_m=0.
  - qualified redirect: flush_d=1, flush_e=1.
  - stall_loaduse: stall_d=1, flush_e=1.
  - Otherwise all controls are 0.
- FSM states:
  - IDLE: issues when `!hold_valid & !qualified redirect & (!f_valid | !stall_d)`. It drives ireq_valid=1 with ireq_addr=pc and goes to BUSY.
  - BUSY: ireq_valid=1, and ireq_addr stays stable at the issued PC until iresp_data_ok.
    - On data_ok with no redirect: the word is accepted, pc <= pc+4, next state IDLE.
    - On qualified redirect without data_ok: pending_pc <= redirect_pc, next state DROP.
    - On redirect and data_ok in the same cycle: the word is discarded, pc <= redirect_pc, next state IDLE.
  - DROP: ireq_valid=0. A new qualified redirect overwrites pending_pc. On data_ok the word is discarded, pc <= pending_pc, next state IDLE.
- Qualified redirect in IDLE: pc <= redirect_pc, and the F/D latch and skid buffer are cleared.
- Accepted word destination:
  - If `f_valid & stall_d`, it goes to the skid buffer (hold_valid, hold_pc, hold_instr).
  - Otherwise it loads the F/D latch.
- F/D latch update, highest priority first:
  1. flush_d: f_valid <= 0 and hold_valid <= 0.
  2. stall_d: hold.
  3. hold_valid: load from the skid buffer and clear hold_valid.
  4. Accepted word this cycle: load it.
  5. Otherwise: f_valid <= 0.
- PC arithmetic is 64-bit and wraps modulo 2^64. No alignment check is made.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, f_valid=0, f_pc=0, f_instr=0, hold_valid=0, pending_pc=0, ireq_valid=0.
- Reset mid-operation discards any in-flight request. The bus is reset by the same signal, so no stale data_ok arrives afterwards.
- First ireq_valid is in the first cycle after reset deasserts, with ireq_addr=RESET_PC.
- Latency:
  - data_ok in cycle N gives f_valid=1 at the edge ending cycle N.
  - The next request issues in cycle N+1.
  - With a zero-wait bus, throughput is one instruction every 2 cycles.
- Redirect in IDLE: the request to redirect_pc issues the next cycle.
- Redirect in BUSY: costs the remaining bus wait plus one cycle.
- flush_d overrides the skid buffer; redirect and buffered data in the same cycle leaves the buffer empty.
- stall_d stays asserted indefinitely without a request being dropped: at most one request is in flight, and the skid buffer absorbs its response.

## Test plan
- Reset release with 1-cycle bus latency:
  - ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - f_pc follows that sequence, with f_valid pulsing every 2 cycles.
- Redirect to 0x8000_0100 while BUSY, data_ok 3 cycles later:
  - ireq_valid drops for those cycles and the returned word never reaches f_valid.
  - The next ireq_addr is 0x8000_0100.
- Redirect coincident with data_ok:
  - The word is discarded, flush_d=flush_e=1, and the next ireq_addr is redirect_pc.
- stall_d held 5 cycles with f_valid=1 and a response arriving:
  - The response is captured in the skid buffer and f_pc/f_instr are unchanged.
  - On release the buffered word appears in the next cycle, and no new request issues until the buffer is empty.
- stall_mem together with redirect and stall_loaduse:
  - stall_d/e/m=1, flush_d=flush_e=0, and pc is unchanged.
  - Dropping stall_mem with redirect held gives flush_d=flush_e=1.
- Reset asserted mid-BUSY (asynchronous):
  - ireq_valid=0 and f_valid=0 immediately.
  - After release, ireq_addr=0x8000_0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC/request sequencer with one-entry skid buffer and pipeline stall/flush controls
module fetch_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        stall_mem,
   input  logic        stall_exe,
   input  logic        stall_loaduse,
   output logic        f_valid,
   output logic [63:0] f_pc,
   output logic [31:0] f_instr,
   output logic        stall_d,
   output logic        stall_e,
   output logic        stall_m,
   output logic        flush_d,
   output logic        flush_e
);
   typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
   state_t state, state_nx;
   logic [63:0] pc, pending_pc, hold_pc;
   logic [31:0] hold_instr;
   logic hold_valid, qred, issue, accept;
   assign qred = redirect & ~stall_mem & ~stall_exe;
   assign stall_m = stall_mem;
   assign stall_e = stall_mem | stall_exe;
   assign stall_d = stall_mem | stall_exe | (stall_loaduse & ~qred);
   assign flush_d = qred;
   assign flush_e = qred | (stall_loaduse & ~stall_mem & ~stall_exe);
   assign ireq_addr = pc;
   assign issue = ~hold_valid & ~qred & (~f_valid | ~stall_d);
   assign accept = (state == BUSY) & iresp_data_ok & ~qred;
   always_comb begin
      state_nx = state;
      ireq_valid = 1'b0;
      case (state)
         IDLE: begin
            ireq_valid = issue & ~reset;
            state_nx = issue ? BUSY : IDLE;
         end
         BUSY: begin
            ireq_valid = 1'b1;
            state_nx = iresp_data_ok ? IDLE : qred ? DROP : BUSY;
         end
         DROP: state_nx = iresp_data_ok ? IDLE : DROP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc <= RESET_PC;
         pending_pc <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (qred) pc <= redirect_pc;
            BUSY: begin
               if (iresp_data_ok) pc <= qred ? redirect_pc : pc + 64'd4;
               else if (qred) pending_pc <= redirect_pc;
            end
            DROP: begin
               if (iresp_data_ok) pc <= qred ? redirect_pc : pending_pc;
               else if (qred) pending_pc <= redirect_pc;
            end
            default: ;
         endcase
      end
   end
   // A bubble in F/D under stall_d is refilled directly; only a valid held entry diverts to the skid buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_valid <= 1'b0;
         f_pc <= '0;
         f_instr <= '0;
         hold_valid <= 1'b0;
         hold_pc <= '0;
         hold_instr <= '0;
      end else if (flush_d) begin
         f_valid <= 1'b0;
         hold_valid <= 1'b0;
      end else if (stall_d & f_valid) begin
         if (accept) begin
            hold_valid <= 1'b1;
            hold_pc <= pc;
            hold_instr <= iresp_data;
         end
      end else if (hold_valid) begin
         f_valid <= 1'b1;
         f_pc <= hold_pc;
         f_instr <= hold_instr;
         hold_valid <= 1'b0;
      end else if (accept) begin
         f_valid <= 1'b1;
         f_pc <= pc;
         f_instr <= iresp_data;
      end else begin
         f_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bus/hazard stimulus against a transaction-level program-flow model with queued expectations
`timescale 1ns/1ps
module tb_fetch_ctrl;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
   logic clk = 1'b0, reset = 1'b1;
   logic ireq_valid, iresp_data_ok, redirect, stall_mem, stall_exe, stall_loaduse;
   logic [63:0] ireq_addr, redirect_pc, f_pc;
   logic [31:0] iresp_data, f_instr;
   logic f_valid, stall_d, stall_e, stall_m, flush_d, flush_e;
   fetch_ctrl dut (
      .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .stall_mem(stall_mem), .stall_exe(stall_exe),
      .stall_loaduse(stall_loaduse), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
      .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e)
   );
   always #5 clk = ~clk;
   typedef struct {bit mark; logic [63:0] pc; logic [31:0] instr;} ent_t;
   ent_t exp_q[$];
   logic [63:0] req_q[$];
   int n_vec = 0, n_err = 0, lat = 0, delivered = 0;
   bit run = 0, quiet = 0, outstanding = 0, doomed = 0, mon_busy = 0, prev_hold = 0;
   logic [63:0] exp_next = RST_PC, req_pc = '0, cur_addr = '0, last_pc = '0;
   logic [31:0] last_instr = '0;
   function automatic logic [31:0] word_of(logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction
   // {stall_d, stall_e, stall_m, flush_d, flush_e} by hazard priority
   function automatic logic [4:0] ctl_of(logic sm, logic se, logic lu, logic rd);
      if (sm) return 5'b11100;
      if (se) return 5'b11000;
      if (rd) return 5'b00011;
      if (lu) return 5'b10001;
      return 5'b00000;
   endfunction
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic zero_inputs();
      iresp_data_ok = 0; iresp_data = '0; redirect = 0; redirect_pc = '0;
      stall_mem = 0; stall_exe = 0; stall_loaduse = 0;
   endtask
   initial begin : drv
      bit ok, qred;
      forever begin
         @(posedge clk); #1;
         ok = 0;
         if (run) begin
            stall_mem = !quiet && $urandom_range(0, 9) == 0;
            stall_exe = !quiet && $urandom_range(0, 9) == 0;
            stall_loaduse = !quiet && $urandom_range(0, 6) == 0;
            redirect = !quiet && $urandom_range(0, 11) == 0;
            redirect_pc = $urandom_range(0, 5) == 0 ? 64'hFFFF_FFFF_FFFF_FFFC : {32'($urandom()), 32'($urandom())};
            if (outstanding && !quiet) begin
               lat--;
               ok = lat == 0;
            end
            iresp_data_ok = ok;
            iresp_data = ok ? word_of(req_pc) : 32'($urandom());
            qred = redirect && !stall_mem && !stall_exe;
            if (qred) begin
               exp_q.push_back('{1'b1, 64'd0, 32'd0});
               exp_next = redirect_pc;
            end
            if (ok && !doomed && !qred) begin
               exp_q.push_back('{1'b0, req_pc, word_of(req_pc)});
               exp_next = req_pc + 64'd4;
            end
            if (qred && outstanding && !ok) doomed = 1;
            if (ok) begin
               outstanding = 0;
               doomed = 0;
            end
         end
         #2;
         if (run && !outstanding && !ok && ireq_valid) begin
            outstanding = 1;
            req_pc = exp_next;
            lat = $urandom_range(1, 4);
            req_q.push_back(exp_next);
         end
      end
   end
   initial begin : mon
      logic [4:0] exp_ctl;
      ent_t e;
      int k;
      forever begin
         @(negedge clk);
         if (run) begin
            exp_ctl = ctl_of(stall_mem, stall_exe, stall_loaduse, redirect);
            check("controls", {59'd0, stall_d, stall_e, stall_m, flush_d, flush_e}, {59'd0, exp_ctl});
            if (ireq_valid) begin
               if (!mon_busy) begin
                  check("req_pending", req_q.size() != 0, 1);
                  if (req_q.size() != 0) cur_addr = req_q.pop_front();
                  mon_busy = 1;
               end
               check("ireq_addr", ireq_addr, cur_addr);
            end
            if (iresp_data_ok) mon_busy = 0;
            if (f_valid) begin
               if (!prev_hold) begin
                  check("fd_pending", exp_q.size() != 0 && !exp_q[0].mark, 1);
                  if (exp_q.size() != 0 && !exp_q[0].mark) begin
                     e = exp_q.pop_front();
                     last_pc = e.pc;
                     last_instr = e.instr;
                     delivered++;
                  end
               end
               check("f_pc", f_pc, last_pc);
               check("f_instr", {32'd0, f_instr}, {32'd0, last_instr});
            end
            // a flush discards every accepted word not yet shown in F/D
            k = -1;
            foreach (exp_q[i]) if (exp_q[i].mark) k = i;
            repeat (k + 1) void'(exp_q.pop_front());
            prev_hold = f_valid && exp_ctl[4];
         end
      end
   end
   initial begin
      zero_inputs();
      repeat (3) @(negedge clk);
      check("rst_ireq_valid", ireq_valid, 0);
      check("rst_ireq_addr", ireq_addr, RST_PC);
      check("rst_f_valid", f_valid, 0);
      check("rst_f_pc", f_pc, 0);
      check("rst_f_instr", f_instr, 0);
      check("rst_controls", {stall_d, stall_e, stall_m, flush_d, flush_e}, 0);
      @(posedge clk); #2;
      reset = 0;
      run = 1;
      repeat (1500) @(posedge clk);
      for (int i = 0; i < 100 && !(outstanding && !doomed); i++) @(negedge clk);
      check("busy_reached", outstanding && !doomed, 1);
      #2;
      run = 0;
      reset = 1;
      #1;
      check("async_rst_ireq_valid", ireq_valid, 0);
      check("async_rst_f_valid", f_valid, 0);
      zero_inputs();
      exp_q.delete();
      req_q.delete();
      outstanding = 0; doomed = 0; mon_busy = 0; prev_hold = 0;
      exp_next = RST_PC;
      repeat (2) @(posedge clk); #2;
      reset = 0;
      run = 1;
      repeat (1500) @(posedge clk);
      quiet = 1;
      repeat (60) @(posedge clk);
      @(negedge clk);
      check("drain_fd", exp_q.size(), 0);
      check("progress", delivered >= 100, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
